// File: rtl/wm_plant_pkg.sv
// Shared types and plant constants for the washing-machine plant model.
// Door FSM state encoding is chosen so that bit 1 alone marks "latch engaged".
package wm_plant_pkg;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'b00,
    LOCKING   = 2'b01,
    LOCKED    = 2'b11,
    UNLOCKING = 2'b10
  } door_state_e;

  localparam int AMBIENT_TEMP   = 20;
  localparam int MAX_TEMP       = 100;
  localparam int HEAT_MIN_LEVEL = 200;
  localparam int SAFE_LEVEL     = 50;
  localparam int SPEED_STEP     = 64;
  localparam int LEVEL_MAX      = 1023;

endpackage

// File: rtl/wm_sat_ramp.sv
// Saturating step-toward-target accumulator: moves value toward target by at
// most STEP per enabled cycle and lands exactly on target, never overshooting.
module wm_sat_ramp #(
  parameter int WIDTH = 10,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] gap;
  logic [WIDTH-1:0] value_next;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    value_next = value;
    gap        = (value < target) ? (target - value) : (value - target);
    if (gap <= WIDTH'(STEP)) begin
      value_next = target;
    end else if (value < target) begin
      value_next = value + WIDTH'(STEP);
    end else begin
      value_next = value - WIDTH'(STEP);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (en) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/wm_plant_model.sv
// Washing-machine plant model: simulates water level, temperature, drum speed,
// vibration and door latch in response to controller actuator commands.
module wm_plant_model
  import wm_plant_pkg::*;
#(
  parameter int TICK_DIV   = 1,
  parameter int FILL_RATE  = 8,
  parameter int DRAIN_RATE = 12,
  parameter int HEAT_DIV   = 8,
  parameter int COOL_DIV   = 32,
  parameter int ACCEL      = 8,
  parameter int LOCK_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       water_valve,
  input  logic       heater,
  input  logic       drain_pump,
  input  logic       door_lock,
  input  logic [3:0] drum_motor,
  input  logic [7:0] load_weight,
  input  logic       unbalance,
  input  logic       fault_no_inflow,
  input  logic       fault_blocked_drain,
  output logic [9:0] water_level_sensor,
  output logic [6:0] temperature_adc_sensor,
  output logic [9:0] motor_speed_sensor,
  output logic       vibration_sensor,
  output logic       door_locked
);

  localparam int VIB_UNBAL_SPEED = 600;
  localparam int VIB_LOAD_SPEED  = 800;
  localparam int VIB_LOAD_MIN    = 200;

  // ---------------- prescaler ----------------
  logic [7:0] presc_cnt;
  logic       tick;

  assign tick = (presc_cnt == 8'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 8'd1;
    end
  end

  // ---------------- water level ----------------
  // 12-bit signed sum holds both LEVEL_MAX+FILL_RATE and 0-DRAIN_RATE without wrapping.
  logic signed [11:0] level_sum;
  logic [9:0]         level_next;

  always_comb begin
    level_sum = $signed({2'b00, water_level_sensor});
    if (water_valve && !fault_no_inflow) begin
      level_sum = level_sum + $signed(12'(FILL_RATE));
    end
    if (drain_pump && !fault_blocked_drain) begin
      level_sum = level_sum - $signed(12'(DRAIN_RATE));
    end
    if (level_sum < 12'sd0) begin
      level_next = '0;
    end else if (level_sum > $signed(12'(LEVEL_MAX))) begin
      level_next = 10'(LEVEL_MAX);
    end else begin
      level_next = level_sum[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      water_level_sensor <= '0;
    end else if (tick) begin
      water_level_sensor <= level_next;
    end
  end

  // ---------------- temperature ----------------
  logic [7:0] heat_cnt;
  logic [7:0] cool_cnt;
  logic       heating;

  assign heating = heater && (water_level_sensor >= 10'(HEAT_MIN_LEVEL));

  always_ff @(posedge clk) begin
    if (reset) begin
      heat_cnt               <= '0;
      cool_cnt               <= '0;
      temperature_adc_sensor <= 7'(AMBIENT_TEMP);
    end else if (tick) begin
      if (heating) begin
        cool_cnt <= '0;
        if (heat_cnt + 8'd1 >= 8'(HEAT_DIV)) begin
          heat_cnt <= '0;
          if (temperature_adc_sensor < 7'(MAX_TEMP)) begin
            temperature_adc_sensor <= temperature_adc_sensor + 7'd1;
          end
        end else begin
          heat_cnt <= heat_cnt + 8'd1;
        end
      end else begin
        heat_cnt <= '0;
        if (cool_cnt + 8'd1 >= 8'(COOL_DIV)) begin
          cool_cnt <= '0;
          if (temperature_adc_sensor > 7'(AMBIENT_TEMP)) begin
            temperature_adc_sensor <= temperature_adc_sensor - 7'd1;
          end
        end else begin
          cool_cnt <= cool_cnt + 8'd1;
        end
      end
    end
  end

  // ---------------- drum motor ----------------
  logic [9:0] speed_target;

  assign speed_target = door_locked ? (10'(drum_motor) * 10'(SPEED_STEP)) : '0;

  wm_sat_ramp #(
    .WIDTH (10),
    .STEP  (ACCEL)
  ) u_speed_ramp (
    .clk    (clk),
    .reset  (reset),
    .en     (tick),
    .target (speed_target),
    .value  (motor_speed_sensor)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vibration_sensor <= 1'b0;
    end else if (tick) begin
      vibration_sensor <= (unbalance && (motor_speed_sensor >= 10'(VIB_UNBAL_SPEED))) ||
                          ((load_weight > 8'(VIB_LOAD_MIN)) &&
                           (motor_speed_sensor >= 10'(VIB_LOAD_SPEED)));
    end
  end

  // ---------------- door latch FSM ----------------
  // lock_cnt counts ticks spent in a transitional state, the entry tick included.
  door_state_e state, state_next;
  logic [7:0]  lock_cnt, lock_cnt_next;

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    case (state)
      UNLOCKED: begin
        if (door_lock) begin
          state_next    = LOCKING;
          lock_cnt_next = 8'd1;
        end
      end
      LOCKING: begin
        if (!door_lock) begin
          state_next    = UNLOCKED;
          lock_cnt_next = '0;
        end else if (lock_cnt + 8'd1 >= 8'(LOCK_DELAY)) begin
          state_next    = LOCKED;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 8'd1;
        end
      end
      LOCKED: begin
        // Interlock: the latch only releases with a stopped drum and a near-empty tub.
        if (!door_lock && (motor_speed_sensor == '0) &&
            (water_level_sensor < 10'(SAFE_LEVEL))) begin
          state_next    = UNLOCKING;
          lock_cnt_next = 8'd1;
        end
      end
      UNLOCKING: begin
        if (door_lock) begin
          state_next    = LOCKED;
          lock_cnt_next = '0;
        end else if (lock_cnt + 8'd1 >= 8'(LOCK_DELAY)) begin
          state_next    = UNLOCKED;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = UNLOCKED;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNLOCKED;
      lock_cnt <= '0;
    end else if (tick) begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  assign door_locked = (state == LOCKED) || (state == UNLOCKING);

endmodule

// File: tb/tb_wm_plant_model.sv
// Directed self-checking bench for wm_plant_model at default parameters
// (one tick per clock); expected values are hand-computed from the plant rules.
module tb_wm_plant_model;

  logic       clk = 1'b0;
  logic       reset;
  logic       water_valve, heater, drain_pump, door_lock;
  logic [3:0] drum_motor;
  logic [7:0] load_weight;
  logic       unbalance, fault_no_inflow, fault_blocked_drain;
  logic [9:0] water_level_sensor;
  logic [6:0] temperature_adc_sensor;
  logic [9:0] motor_speed_sensor;
  logic       vibration_sensor, door_locked;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wm_plant_model dut (
    .clk                    (clk),
    .reset                  (reset),
    .water_valve            (water_valve),
    .heater                 (heater),
    .drain_pump             (drain_pump),
    .door_lock              (door_lock),
    .drum_motor             (drum_motor),
    .load_weight            (load_weight),
    .unbalance              (unbalance),
    .fault_no_inflow        (fault_no_inflow),
    .fault_blocked_drain    (fault_blocked_drain),
    .water_level_sensor     (water_level_sensor),
    .temperature_adc_sensor (temperature_adc_sensor),
    .motor_speed_sensor     (motor_speed_sensor),
    .vibration_sensor       (vibration_sensor),
    .door_locked            (door_locked)
  );

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    water_valve         = 1'b0;
    heater              = 1'b0;
    drain_pump          = 1'b0;
    door_lock           = 1'b0;
    drum_motor          = 4'd0;
    load_weight         = 8'd0;
    unbalance           = 1'b0;
    fault_no_inflow     = 1'b0;
    fault_blocked_drain = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, water_level_sensor, 0);
    check({tag, "_temp"}, temperature_adc_sensor, 20);
    check({tag, "_speed"}, motor_speed_sensor, 0);
    check({tag, "_vib"}, vibration_sensor, 0);
    check({tag, "_door"}, door_locked, 0);
  endtask

  initial begin
    // Reset held with arbitrary actuator and fault inputs.
    reset               = 1'b1;
    water_valve         = 1'($urandom);
    heater              = 1'($urandom);
    drain_pump          = 1'($urandom);
    door_lock           = 1'($urandom);
    drum_motor          = 4'($urandom);
    load_weight         = 8'($urandom);
    unbalance           = 1'($urandom);
    fault_no_inflow     = 1'($urandom);
    fault_blocked_drain = 1'($urandom);
    cycles(3);
    check_reset_state("reset");
    clear_inputs();
    reset = 1'b0;

    // Heater with an empty tub must not heat.
    heater = 1'b1;
    cycles(16);
    check("heat_dry_tub", temperature_adc_sensor, 20);
    heater = 1'b0;

    // Inflow fault blocks filling immediately.
    water_valve     = 1'b1;
    fault_no_inflow = 1'b1;
    cycles(5);
    check("no_inflow", water_level_sensor, 0);
    fault_no_inflow = 1'b0;

    // Fill, fill+drain, drain to empty.
    cycles(30);
    check("fill_30", water_level_sensor, 240);
    drain_pump = 1'b1;
    cycles(5);
    check("fill_drain_5", water_level_sensor, 220);
    water_valve = 1'b0;
    cycles(20);
    check("drain_floor", water_level_sensor, 0);
    drain_pump = 1'b0;

    // Refill, heat, then cool back to ambient.
    water_valve = 1'b1;
    cycles(30);
    check("refill_30", water_level_sensor, 240);
    water_valve = 1'b0;
    heater      = 1'b1;
    cycles(40);
    check("heat_40", temperature_adc_sensor, 25);
    cycles(40);
    check("heat_80", temperature_adc_sensor, 30);
    heater = 1'b0;
    cycles(160);
    check("cool_160", temperature_adc_sensor, 25);
    cycles(160);
    check("cool_320", temperature_adc_sensor, 20);
    cycles(40);
    check("cool_floor", temperature_adc_sensor, 20);

    // Blocked drain holds the level.
    drain_pump          = 1'b1;
    fault_blocked_drain = 1'b1;
    cycles(10);
    check("blocked_drain", water_level_sensor, 240);
    drain_pump          = 1'b0;
    fault_blocked_drain = 1'b0;

    // Door latch and speed ramp.
    door_lock = 1'b1;
    cycles(3);
    check("door_locking_3", door_locked, 0);
    cycles(1);
    check("door_locked_4", door_locked, 1);
    drum_motor = 4'd10;
    cycles(79);
    check("speed_79", motor_speed_sensor, 632);
    cycles(1);
    check("speed_80", motor_speed_sensor, 640);
    cycles(10);
    check("speed_clamp", motor_speed_sensor, 640);
    check("vib_no_cause", vibration_sensor, 0);
    door_lock = 1'b0;
    cycles(10);
    check("interlock_spin", door_locked, 1);
    drum_motor = 4'd0;
    cycles(90);
    check("spin_down", motor_speed_sensor, 0);
    check("interlock_water", door_locked, 1);
    drain_pump = 1'b1;
    cycles(30);
    check("unlock_level", water_level_sensor, 0);
    check("unlock_done", door_locked, 0);
    drain_pump = 1'b0;

    // Vibration from unbalance, then from heavy load.
    reset = 1'b1;
    cycles(1);
    reset     = 1'b0;
    door_lock = 1'b1;
    cycles(4);
    check("vib_door", door_locked, 1);
    drum_motor = 4'd15;
    unbalance  = 1'b1;
    cycles(74);
    check("vib_speed_592", motor_speed_sensor, 592);
    cycles(1);
    check("vib_speed_600", motor_speed_sensor, 600);
    check("vib_not_yet", vibration_sensor, 0);
    cycles(1);
    check("vib_unbalance", vibration_sensor, 1);
    unbalance   = 1'b0;
    load_weight = 8'd201;
    cycles(1);
    check("vib_load_slow", vibration_sensor, 0);
    cycles(23);
    check("vib_speed_800", motor_speed_sensor, 800);
    check("vib_load_pending", vibration_sensor, 0);
    cycles(1);
    check("vib_load", vibration_sensor, 1);
    load_weight = 8'd200;
    cycles(1);
    check("vib_load_200", vibration_sensor, 0);

    // Reset mid-fill overrides the update on that edge.
    clear_inputs();
    reset = 1'b1;
    cycles(1);
    reset       = 1'b0;
    water_valve = 1'b1;
    cycles(10);
    check("midfill_level", water_level_sensor, 80);
    reset = 1'b1;
    cycles(1);
    check_reset_state("midfill_reset");
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
